data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the single-port `DataMemory`. It shares the memory between the CPU data port (port A) and a loader/DMA port (port B). Grants are round-robin. Each granted request is latched, driven onto the memory for exactly one cycle, and returned with a registered Ack/RData. Misaligned or out-of-range accesses are rejected with an error response and never reach the memory.

---
 rtl/data_mem_arbiter_pkg.sv | 24 ++
 rtl/data_mem_arbiter_if.sv | 28 ++
 rtl/data_mem_arbiter_rr_arb2.sv | 27 ++
 rtl/data_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the DataMemory arbiter: FSM encoding, port IDs and
// the address legality rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned DMEM_WORD_AW = 10;

  // Word-aligned and inside [0, 4*2^word_aw); a span >= 32 bits leaves no high bits to test.
  function automatic logic dmem_addr_legal(input logic [31:0] addr,
                                           input int unsigned word_aw = DMEM_WORD_AW);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (word_aw + 32'd2)) - 32'd1);
    return (addr[1:0] == 2'b00) && ((addr & hi_mask) == '0);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and DataMemory.
interface data_mem_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              ReqA, ReqB;
  logic              WrA, WrB;
  logic [31:0]       AddrA, AddrB;
  logic [DATA_W-1:0] WDataA, WDataB;
  logic              AckA, AckB;
  logic              ErrA, ErrB;
  logic [DATA_W-1:0] RDataA, RDataB;
  logic [31:0]       MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemWrite, MemRead;
  logic [DATA_W-1:0] MemReadData;

  modport slave (
    input  ReqA, ReqB, WrA, WrB, AddrA, AddrB, WDataA, WDataB, MemReadData,
    output AckA, AckB, ErrA, ErrB, RDataA, RDataB,
           MemAddress, MemWriteData, MemWrite, MemRead
  );

  modport master (
    output ReqA, ReqB, WrA, WrB, AddrA, AddrB, WDataA, WDataB, MemReadData,
    input  AckA, AckB, ErrA, ErrB, RDataA, RDataB,
           MemAddress, MemWriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; purely combinational, the last-grant flop
// lives in the parent.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic [1:0] eligible;

  always_comb begin
    eligible  = req & ~mask;
    gnt_valid = |eligible;
    gnt_id    = PORT_A;
    case (eligible)
      2'b01:   gnt_id = PORT_A;
      2'b10:   gnt_id = PORT_B;
      2'b11:   gnt_id = ~last;
      default: gnt_id = PORT_A;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing single-port DataMemory between the
// CPU data port (A) and the loader port (B).
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORD_AW = 10
) (
  input  logic               Clk,
  input  logic               Reset_n,
  data_mem_arbiter_if.slave  bus
);

  dmem_arb_state_t   state;
  logic              last;
  logic              cur_id;
  logic              lat_wr;
  logic              lat_legal;
  logic              ack_a, ack_b, err_a, err_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read, mem_write;

  logic [1:0]        arb_mask;
  logic              gnt_valid, gnt_id;
  logic              sel_wr, sel_legal;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // In RESP the served port's Req may still be high, so it sits out this round.
  always_comb begin
    arb_mask = 2'b00;
    if (state == RESP) arb_mask = (cur_id == PORT_A) ? 2'b01 : 2'b10;
  end

  rr_arb2 u_arb (
    .req       ({bus.ReqB, bus.ReqA}),
    .last      (last),
    .mask      (arb_mask),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    sel_wr    = (gnt_id == PORT_B) ? bus.WrB    : bus.WrA;
    sel_addr  = (gnt_id == PORT_B) ? bus.AddrB  : bus.AddrA;
    sel_wdata = (gnt_id == PORT_B) ? bus.WDataB : bus.WDataA;
    sel_legal = dmem_addr_legal(sel_addr, WORD_AW);
  end

  // Mem* outputs are loaded at the granting edge so they are registered and
  // valid for exactly the ACCESS cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      last      <= PORT_B;
      cur_id    <= PORT_A;
      lat_wr    <= 1'b0;
      lat_legal <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      err_a     <= 1'b0;
      err_b     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (gnt_valid) begin
            last      <= gnt_id;
            cur_id    <= gnt_id;
            lat_wr    <= sel_wr;
            lat_legal <= sel_legal;
            mem_addr  <= sel_legal ? sel_addr : '0;
            mem_wdata <= sel_legal ? sel_wdata : '0;
            mem_read  <= sel_legal & ~sel_wr;
            mem_write <= sel_legal & sel_wr;
            state     <= ACCESS;
          end else begin
            state     <= IDLE;
          end
        end
        ACCESS: begin
          if (cur_id == PORT_A) begin
            ack_a <= 1'b1;
            err_a <= ~lat_legal;
            if (lat_legal && !lat_wr) rdata_a <= bus.MemReadData;
          end else begin
            ack_b <= 1'b1;
            err_b <= ~lat_legal;
            if (lat_legal && !lat_wr) rdata_b <= bus.MemReadData;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.AckA         = ack_a;
  assign bus.AckB         = ack_b;
  assign bus.ErrA         = err_a;
  assign bus.ErrB         = err_b;
  assign bus.RDataA       = rdata_a;
  assign bus.RDataB       = rdata_b;
  assign bus.MemAddress   = mem_addr;
  assign bus.MemWriteData = mem_wdata;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed plus random traffic
// against a transaction-level model of arbitration order and memory contents.
module tb_data_mem_arbiter;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  data_mem_arbiter_if #(.DATA_W(32)) bus ();

  data_mem_arbiter #(.DATA_W(32), .WORD_AW(10)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // DataMemory stand-in: combinational read, write on the rising edge.
  logic [31:0] dmem [0:1023];
  assign bus.MemReadData = dmem[bus.MemAddress[11:2]];
  always @(posedge Clk) if (bus.MemWrite) dmem[bus.MemAddress[11:2]] <= bus.MemWriteData;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [int unsigned];
  int          model_last = 1;
  logic [31:0] exp_rd [2];
  bit          rd_known [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd4096);
  endfunction

  task automatic model_reset();
    model_last  = 1;
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
    rd_known[0] = 1'b1;
    rd_known[1] = 1'b1;
  endtask

  task automatic model_complete(input int p, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    if (is_legal(a) && wr) ref_mem[a / 4] = wd;
    else if (is_legal(a) && !wr) begin
      if (ref_mem.exists(a / 4)) begin
        exp_rd[p]   = ref_mem[a / 4];
        rd_known[p] = 1'b1;
      end else rd_known[p] = 1'b0;
    end else if (!wr) rd_known[p] = 1'b0;
  endtask

  task automatic check_rdata();
    if (rd_known[0]) check("RDataA", bus.RDataA, exp_rd[0]);
    if (rd_known[1]) check("RDataB", bus.RDataB, exp_rd[1]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_AckA"}, bus.AckA, 0);
    check({tag, "_AckB"}, bus.AckB, 0);
    check({tag, "_ErrA"}, bus.ErrA, 0);
    check({tag, "_ErrB"}, bus.ErrB, 0);
    check({tag, "_RDataA"}, bus.RDataA, 0);
    check({tag, "_RDataB"}, bus.RDataB, 0);
    check({tag, "_MemAddress"}, bus.MemAddress, 0);
    check({tag, "_MemWriteData"}, bus.MemWriteData, 0);
    check({tag, "_MemRead"}, bus.MemRead, 0);
    check({tag, "_MemWrite"}, bus.MemWrite, 0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    model_reset();
  endtask

  // One request per enabled port, presented together; checked cycle by cycle
  // against the expected grant order for five cycles.
  task automatic run_pair(input bit ena, input bit wra, input logic [31:0] addra, input logic [31:0] wda,
                          input bit enb, input bit wrb, input logic [31:0] addrb, input logic [31:0] wdb,
                          input bit move_a);
    bit          en [2];
    bit          wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    int          acc_cyc [2];
    int          first, second, ap, kp;
    en[0] = ena; wr[0] = wra; ad[0] = addra; wd[0] = wda;
    en[1] = enb; wr[1] = wrb; ad[1] = addrb; wd[1] = wdb;
    acc_cyc[0] = -10; acc_cyc[1] = -10;
    if (ena && enb) begin
      first = 1 - model_last; second = model_last;
      acc_cyc[first] = 1; acc_cyc[second] = 3;
      model_last = second;
    end else if (ena || enb) begin
      first = ena ? 0 : 1;
      acc_cyc[first] = 1;
      model_last = first;
    end
    @(negedge Clk);
    bus.ReqA = ena; bus.WrA = wra; bus.AddrA = addra; bus.WDataA = wda;
    bus.ReqB = enb; bus.WrB = wrb; bus.AddrB = addrb; bus.WDataB = wdb;
    for (int c = 1; c <= 5; c++) begin
      @(posedge Clk); #1;
      ap = (acc_cyc[0] == c) ? 0 : (acc_cyc[1] == c) ? 1 : -1;
      kp = (acc_cyc[0] + 1 == c) ? 0 : (acc_cyc[1] + 1 == c) ? 1 : -1;
      check("AckA", bus.AckA, kp == 0);
      check("AckB", bus.AckB, kp == 1);
      check("ErrA", bus.ErrA, kp == 0 && !is_legal(ad[0]));
      check("ErrB", bus.ErrB, kp == 1 && !is_legal(ad[1]));
      check("MemRead",  bus.MemRead,  ap >= 0 && is_legal(ad[ap]) && !wr[ap]);
      check("MemWrite", bus.MemWrite, ap >= 0 && is_legal(ad[ap]) && wr[ap]);
      if (ap >= 0 && is_legal(ad[ap])) begin
        check("MemAddress", bus.MemAddress, ad[ap]);
        if (wr[ap]) check("MemWriteData", bus.MemWriteData, wd[ap]);
      end
      if (kp >= 0) begin
        model_complete(kp, wr[kp], ad[kp], wd[kp]);
        if (kp == 0) bus.ReqA = 1'b0; else bus.ReqB = 1'b0;
      end
      check_rdata();
      if (move_a && c == 1) begin
        bus.AddrA  = 32'h20;
        bus.WDataA = ~wda;
        #1;
        check("latch_MemAddress", bus.MemAddress, ad[0]);
        check("latch_MemWriteData", bus.MemWriteData, wd[0]);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
    if (r == 1) return 32'h1000 + ($urandom_range(0, 255) << 2);
    return $urandom_range(0, 15) << 2;
  endfunction

  initial begin
    int first, exp_p, mode;
    logic [31:0] iso_data;
    Reset_n = 1'b0;
    bus.ReqA = 0; bus.WrA = 0; bus.AddrA = '0; bus.WDataA = '0;
    bus.ReqB = 0; bus.WrB = 0; bus.AddrB = '0; bus.WDataB = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // Uncontended write then read-back
    run_pair(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("dmem_word4", dmem[4], 32'hDEADBEEF);
    run_pair(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    check("readback_A", bus.RDataA, 32'hDEADBEEF);

    // Fill words 0..15 (except 4) through alternating ports
    for (int w = 0; w < 16; w++) begin
      if (w != 4) begin
        if (w % 2 == 0) run_pair(1, 1, w * 4, $urandom, 0, 0, 0, 0, 0);
        else            run_pair(0, 0, 0, 0, 1, 1, w * 4, $urandom, 0);
      end
    end

    // Simultaneous reads straight after reset: A wins the tie
    do_reset();
    run_pair(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 0);

    // Fairness with both ports held for 8 grants
    bus.WrA = 0; bus.AddrA = 32'h8;
    bus.WrB = 0; bus.AddrB = 32'hC;
    @(negedge Clk);
    bus.ReqA = 1; bus.ReqB = 1;
    first = 1 - model_last;
    for (int c = 1; c <= 18; c++) begin
      @(posedge Clk); #1;
      exp_p = -1;
      if (c % 2 == 0 && c <= 16) exp_p = (((c / 2) - 1) % 2 == 0) ? first : 1 - first;
      check("fair_AckA", bus.AckA, exp_p == 0);
      check("fair_AckB", bus.AckB, exp_p == 1);
      check("fair_MemRead", bus.MemRead, (c % 2 == 1) && c <= 15);
      if (exp_p >= 0) begin
        model_complete(exp_p, 1'b0, exp_p == 0 ? 32'h8 : 32'hC, '0);
        model_last = exp_p;
      end
      check_rdata();
      if (c == 16) begin
        bus.ReqA = 0; bus.ReqB = 0;
      end
    end

    // Illegal addresses on port B
    run_pair(0, 0, 0, 0, 1, 1, 32'h2, 32'h12345678, 0);
    run_pair(0, 0, 0, 0, 1, 0, 32'h1000, 0, 0);

    // Latch isolation: AddrA moves to 0x20 during ACCESS
    iso_data = $urandom;
    run_pair(1, 1, 32'h10, iso_data, 0, 0, 0, 0, 1);
    run_pair(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    check("iso_word4", bus.RDataA, iso_data);
    run_pair(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);

    // Reset asserted during ACCESS of an A read
    @(negedge Clk);
    bus.ReqA = 1; bus.WrA = 0; bus.AddrA = 32'h10; bus.ReqB = 0;
    @(posedge Clk); #1;
    check("rst_pre_MemRead", bus.MemRead, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge Clk); #1;
    check("rst_no_AckA", bus.AckA, 0);
    Reset_n = 1'b1;
    model_reset();
    run_pair(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 2);
      run_pair(mode != 1, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
               mode != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
